// File: rtl/cache_axi_read_arbiter.sv
// cache_axi_read_arbiter: shares one AXI4 read channel between the ICache and
// DCache refill ports, issuing one LINE_WORDS-beat INCR burst per grant and
// returning the assembled line as a one-cycle valid pulse to the winner.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// otherwise the DCache wins simultaneous requests (fixed priority).
module cache_axi_read_arbiter #(
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned ID_W       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_ren_i,
  input  logic [ADDR_W-1:0]          inst_araddr_i,
  output logic                       inst_rvalid_o,
  output logic [32*LINE_WORDS-1:0]   inst_rdata_o,
  input  logic                       data_ren_i,
  input  logic [ADDR_W-1:0]          data_araddr_i,
  output logic                       data_rvalid_o,
  output logic [32*LINE_WORDS-1:0]   data_rdata_o,
  output logic [ID_W-1:0]            arid,
  output logic [ADDR_W-1:0]          araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [31:0]                rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready,
  output logic                       busy_o,
  output logic                       bus_err_o
);

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BEAT_W     = $clog2(LINE_WORDS);
  localparam int unsigned LINE_BYTES = LINE_WORDS * (WORD_W / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                               state_q, state_d;
  logic                                 grant_q;
  logic                                 grant_c;
  logic                                 req_c;
  logic [ADDR_W-1:0]                    win_addr_c;
  logic [BEAT_W-1:0]                    beat_q;
  logic                                 last_beat_c;
  logic                                 beat_fire_c;
  logic [LINE_WORDS-1:0][WORD_W-1:0]    line_q;

  // Fixed burst shape: LINE_WORDS beats of 4 bytes, incrementing
  assign arlen   = 8'(LINE_WORDS - 1);
  assign arsize  = 3'b010;
  assign arburst = 2'b01;

  // Both caches see the same line buffer; only the rvalid pulse is steered
  assign inst_rdata_o = line_q;
  assign data_rdata_o = line_q;

  assign req_c       = inst_ren_i | data_ren_i;
  assign last_beat_c = (beat_q == BEAT_W'(LINE_WORDS - 1));
  assign beat_fire_c = (state_q == S_R) && rvalid;

  // Grant selection; grant_q doubles as last_grant for round robin
  always_comb begin
    grant_c = data_ren_i;
`ifdef ARB_ROUND_ROBIN_EN
    if (inst_ren_i && data_ren_i) begin
      grant_c = ~grant_q;
    end
`endif
    win_addr_c = grant_c ? data_araddr_i : inst_araddr_i;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; arvalid/rready come straight from the state
  always_comb begin
    state_d = state_q;
    arvalid = 1'b0;
    rready  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_c) state_d = S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_d = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && last_beat_c) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Request latch, beat assembly, status and response pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= 1'b1;
      araddr        <= '0;
      arid          <= '0;
      beat_q        <= '0;
      line_q        <= '0;
      inst_rvalid_o <= 1'b0;
      data_rvalid_o <= 1'b0;
      busy_o        <= 1'b0;
      bus_err_o     <= 1'b0;
    end else begin
      inst_rvalid_o <= (state_d == S_DONE) && !grant_q;
      data_rvalid_o <= (state_d == S_DONE) &&  grant_q;
      busy_o        <= (state_d != S_IDLE);
      if (state_q == S_IDLE && req_c) begin
        grant_q <= grant_c;
        araddr  <= win_addr_c & ~ADDR_W'(LINE_BYTES - 1);
        arid    <= ID_W'(grant_c);
      end
      if (state_q == S_AR && arready) begin
        beat_q <= '0;
      end
      if (beat_fire_c) begin
        line_q[beat_q] <= rdata;
        beat_q         <= beat_q + 1'b1;
        // Slave errors and rlast misplacement are flagged but the line still completes
        if ((rresp != 2'b00) || (rlast != last_beat_c)) begin
          bus_err_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_cache_axi_read_arbiter.sv
// Self-checking bench for cache_axi_read_arbiter: table of single-burst
// vectors plus hand sequences for held requests, mid-burst reset and rlast
// errors. Expected lines go into a scoreboard queue at the AR handshake and
// are compared when the DUT pulses rvalid_o.
module tb_cache_axi_read_arbiter;

  logic         clk;
  logic         rst;
  logic         inst_ren_i;
  logic [31:0]  inst_araddr_i;
  logic         inst_rvalid_o;
  logic [255:0] inst_rdata_o;
  logic         data_ren_i;
  logic [31:0]  data_araddr_i;
  logic         data_rvalid_o;
  logic [255:0] data_rdata_o;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic         busy_o;
  logic         bus_err_o;

  cache_axi_read_arbiter dut (
    .clk(clk), .rst(rst),
    .inst_ren_i(inst_ren_i), .inst_araddr_i(inst_araddr_i),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o),
    .data_ren_i(data_ren_i), .data_araddr_i(data_araddr_i),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .busy_o(busy_o), .bus_err_o(bus_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         port;
    logic [255:0] line;
  } exp_t;

  typedef struct {
    logic        inst_req;
    logic        data_req;
    logic [31:0] inst_addr;
    logic [31:0] data_addr;
    int          ar_stall;
    bit          r_gap;
    int          bad_beat;
    int          early_beat;
    logic [31:0] base;
    logic [3:0]  exp_id;
    logic [31:0] exp_addr;
    int          exp_lat;
    logic        exp_err;
  } vec_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string p);
    check({p, "_arvalid"}, arvalid, 0);
    check({p, "_rready"}, rready, 0);
    check({p, "_inst_rvalid"}, inst_rvalid_o, 0);
    check({p, "_data_rvalid"}, data_rvalid_o, 0);
    check({p, "_busy"}, busy_o, 0);
    check({p, "_err"}, bus_err_o, 0);
    check({p, "_araddr"}, araddr, 0);
    check({p, "_arid"}, arid, 0);
    check({p, "_inst_rdata"}, inst_rdata_o, 0);
    check({p, "_data_rdata"}, data_rdata_o, 0);
    check({p, "_arlen"}, arlen, 8'd7);
    check({p, "_arsize"}, arsize, 3'b010);
    check({p, "_arburst"}, arburst, 2'b01);
  endtask

  // Slave model for one burst; starts in the cycle where the request is seen
  task automatic serve(input string tag, input int ar_stall, input bit r_gap,
                       input int bad_beat, input int early_beat, input logic [31:0] base,
                       input logic [3:0] exp_id, input logic [31:0] exp_addr,
                       input int exp_lat, input bit drop);
    int           stall = ar_stall;
    int           beat  = 0;
    bit           gap   = 1'b0;
    bit           got   = 1'b0;
    int           lat   = 0;
    exp_t         e;
    logic [255:0] act;
    arready = 1'b0;
    rvalid  = 1'b0;
    for (int cyc = 1; cyc <= 300 && !got; cyc++) begin
      tick();
      if (inst_rvalid_o || data_rvalid_o) begin
        got     = 1'b1;
        lat     = cyc;
        rvalid  = 1'b0;
        arready = 1'b0;
      end else begin
        if (arvalid) begin
          check({tag, "_araddr"}, araddr, exp_addr);
          check({tag, "_arid"}, arid, exp_id);
          if (stall > 0) begin
            stall--;
            arready = 1'b0;
          end else begin
            arready = 1'b1;
            e.port = exp_id[0];
            for (int i = 0; i < 8; i++) e.line[32*i +: 32] = base + 32'(i);
            exp_q.push_back(e);
          end
        end else begin
          arready = 1'b0;
        end
        if (rready && beat < 8 && !gap) begin
          rvalid = 1'b1;
          rdata  = base + 32'(beat);
          rresp  = (beat == bad_beat) ? 2'b10 : 2'b00;
          rlast  = (beat == 7) || (beat == early_beat);
          beat++;
          gap = r_gap;
        end else begin
          rvalid = 1'b0;
          gap    = 1'b0;
        end
      end
    end
    if (!got) begin
      fail({tag, "_timeout"});
    end else begin
      check({tag, "_latency"}, lat, exp_lat);
      check({tag, "_both_pulse"}, inst_rvalid_o & data_rvalid_o, 0);
      if (exp_q.size() == 0) begin
        fail({tag, "_scoreboard_entry"});
      end else begin
        e = exp_q.pop_front();
        check({tag, "_port"}, data_rvalid_o, e.port);
        act = e.port ? data_rdata_o : inst_rdata_o;
        check({tag, "_line"}, act, e.line);
      end
    end
    if (drop) begin
      inst_ren_i = 1'b0;
      data_ren_i = 1'b0;
    end
    tick();
    check({tag, "_pulse_width"}, inst_rvalid_o | data_rvalid_o, 0);
    check({tag, "_idle_after"}, busy_o, 0);
  endtask

  vec_t       vecs[6];
  logic [3:0] held_ids[3];

  initial begin
    bit ok;
    rst = 1'b1;
    inst_ren_i = 1'b0; inst_araddr_i = '0;
    data_ren_i = 1'b0; data_araddr_i = '0;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;

    vecs[0] = '{1'b1, 1'b0, 32'h1FC0_0014, 32'h0, 0, 1'b0, -1, -1, 32'hA0,
                4'd0, 32'h1FC0_0000, 10, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0, 32'h8000_103F, 0, 1'b0, -1, -1, 32'h1000,
                4'd1, 32'h8000_1020, 10, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0, 5, 1'b1, -1, -1, 32'h2000,
                4'd0, 32'h0000_0040, 22, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0100, 32'h0000_0204, 0, 1'b0, -1, -1, 32'h3000,
                4'd1, 32'h0000_0200, 10, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 32'h0, 32'hFFFF_FFFC, 0, 1'b0, 3, -1, 32'h4000,
                4'd1, 32'hFFFF_FFE0, 10, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_1234, 32'h0, 0, 1'b0, -1, -1, 32'h5000,
                4'd0, 32'h0000_1220, 10, 1'b1};
`ifdef ARB_ROUND_ROBIN_EN
    held_ids[0] = 4'd0; held_ids[1] = 4'd1; held_ids[2] = 4'd0;
`else
    held_ids[0] = 4'd1; held_ids[1] = 4'd1; held_ids[2] = 4'd1;
`endif

    tick();
    tick();
    check_reset("por");
    rst = 1'b0;
    tick();
    check("por_idle_busy", busy_o, 0);

    // Single-burst vectors
    for (int i = 0; i < 6; i++) begin
      inst_araddr_i = vecs[i].inst_addr;
      data_araddr_i = vecs[i].data_addr;
      inst_ren_i    = vecs[i].inst_req;
      data_ren_i    = vecs[i].data_req;
      serve($sformatf("v%0d", i), vecs[i].ar_stall, vecs[i].r_gap, vecs[i].bad_beat,
            vecs[i].early_beat, vecs[i].base, vecs[i].exp_id, vecs[i].exp_addr,
            vecs[i].exp_lat, 1'b1);
      check($sformatf("v%0d_err", i), bus_err_o, vecs[i].exp_err);
    end

    // Both requests held: grant order and back-to-back latency
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("held_err_cleared", bus_err_o, 0);
    inst_araddr_i = 32'h1000_0008;
    data_araddr_i = 32'h2000_0010;
    inst_ren_i = 1'b1;
    data_ren_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      serve($sformatf("held%0d", k), 0, 1'b0, -1, -1, 32'h100 * 32'(k + 1),
            held_ids[k], held_ids[k][0] ? 32'h2000_0000 : 32'h1000_0000, 10, k == 2);
    end

    // Reset after beat 4 of an ICache burst
    inst_araddr_i = 32'h0000_0300;
    inst_ren_i = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      if (arvalid) ok = 1'b1;
    end
    if (!ok) fail("mid_rst_arvalid");
    arready = 1'b1;
    tick();
    arready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      rvalid = 1'b1;
      rdata  = 32'hDEAD_0000 + 32'(b);
      rresp  = 2'b00;
      rlast  = 1'b0;
      tick();
    end
    rvalid = 1'b0;
    inst_ren_i = 1'b0;
    rst = 1'b1;
    tick();
    check_reset("mid_rst");
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("mid_rst_nopulse%0d", i), inst_rvalid_o | data_rvalid_o, 0);
      check($sformatf("mid_rst_busy%0d", i), busy_o, 0);
    end
    inst_ren_i = 1'b1;
    serve("after_rst", 0, 1'b0, -1, -1, 32'hC0, 4'd0, 32'h0000_0300, 10, 1'b1);
    check("after_rst_err", bus_err_o, 0);

    // Early rlast on beat 5
    data_araddr_i = 32'h0000_0044;
    data_ren_i = 1'b1;
    serve("early_last", 0, 1'b0, -1, 5, 32'hE0, 4'd1, 32'h0000_0040, 10, 1'b1);
    check("early_last_err", bus_err_o, 1);

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
